// File: rtl/seq101_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : seq101_tx_if
// Brief   : Load handshake and serial output bundle for seq101_tx.
// Revision: 1.0 - initial release
// ============================================================================
interface seq101_tx_if #(
    parameter int DATA_W = 8
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              dout;
    logic              dout_en;
    logic              busy;
    logic              done;

    modport master (
        output load_valid, load_data,
        input  load_ready, dout, dout_en, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, dout, dout_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq101_tx.sv
`default_nettype none
// ============================================================================
// Module  : seq101_tx
// Brief   : Serial frame transmitter: preamble "101", then payload MSB-first,
//           optional even-parity bit (macro SEQ101_TX_PARITY_EN), then idle gap.
// Revision: 1.0 - initial release
// ============================================================================
module seq101_tx #(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq101_tx_if.slave  bus
);
    localparam int BCW = $clog2(DATA_W + 1);
    // Auxiliary counter times the preamble (3 cycles) and the gap.
    localparam int ACW = (GAP_CYC > 4) ? $clog2(GAP_CYC) : 2;

    localparam logic [4:0] c_IDLE = 5'b00001;
    localparam logic [4:0] c_PRE  = 5'b00010;
    localparam logic [4:0] c_DATA = 5'b00100;
`ifdef SEQ101_TX_PARITY_EN
    localparam logic [4:0] c_PAR  = 5'b01000;
`endif
    localparam logic [4:0] c_GAP  = 5'b10000;

    localparam logic [BCW-1:0] c_BIT_LAST = BCW'(DATA_W - 1);
    localparam logic [ACW-1:0] c_PRE_LAST = ACW'(2);
    localparam logic [ACW-1:0] c_GAP_LAST = ACW'(GAP_CYC - 1);

    logic [4:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BCW-1:0]    r_bit_cnt;
    logic [ACW-1:0]    r_aux_cnt;
`ifdef SEQ101_TX_PARITY_EN
    logic              r_par;
`endif

    logic w_ready;
    logic w_dout;
    logic w_dout_en;
    logic w_busy;
    logic w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_aux_cnt <= '0;
`ifdef SEQ101_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.load_valid) begin
                        r_shift   <= bus.load_data;
`ifdef SEQ101_TX_PARITY_EN
                        r_par     <= ^bus.load_data;
`endif
                        r_aux_cnt <= c_PRE_LAST;
                        r_state   <= c_PRE;
                    end
                end
                c_PRE: begin
                    if (r_aux_cnt == '0) begin
                        r_bit_cnt <= c_BIT_LAST;
                        r_state   <= c_DATA;
                    end else begin
                        r_aux_cnt <= r_aux_cnt - 1'b1;
                    end
                end
                c_DATA: begin
                    r_shift <= r_shift << 1;
                    if (r_bit_cnt == '0) begin
`ifdef SEQ101_TX_PARITY_EN
                        r_state   <= c_PAR;
`else
                        r_aux_cnt <= c_GAP_LAST;
                        r_state   <= c_GAP;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
`ifdef SEQ101_TX_PARITY_EN
                c_PAR: begin
                    r_aux_cnt <= c_GAP_LAST;
                    r_state   <= c_GAP;
                end
`endif
                c_GAP: begin
                    if (r_aux_cnt == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_aux_cnt <= r_aux_cnt - 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Moore decode; any non-legal encoding yields reset-value outputs.
    always_comb begin
        w_ready   = 1'b0;
        w_dout    = 1'b0;
        w_dout_en = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            c_IDLE: w_ready = 1'b1;
            c_PRE: begin
                w_dout    = ~r_aux_cnt[0];
                w_dout_en = 1'b1;
                w_busy    = 1'b1;
            end
            c_DATA: begin
                w_dout    = r_shift[DATA_W-1];
                w_dout_en = 1'b1;
                w_busy    = 1'b1;
            end
`ifdef SEQ101_TX_PARITY_EN
            c_PAR: begin
                w_dout    = r_par;
                w_dout_en = 1'b1;
                w_busy    = 1'b1;
            end
`endif
            c_GAP: begin
                w_busy = 1'b1;
                w_done = (r_aux_cnt == '0);
            end
            default: ;
        endcase
    end

    assign bus.load_ready = w_ready & ~rst;
    assign bus.dout       = w_dout;
    assign bus.dout_en    = w_dout_en;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
endmodule
`default_nettype wire

// File: tb/tb_seq101_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq101_tx
// Brief   : Self-checking bench for seq101_tx with a serial-bit scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq101_tx;
    localparam int DATA_W  = 8;
    localparam int GAP_CYC = 2;
`ifdef SEQ101_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = 3 + DATA_W + PAR_BITS;

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq101_tx_if #(.DATA_W(DATA_W)) bus();

    seq101_tx #(.DATA_W(DATA_W), .GAP_CYC(GAP_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic mon_exp;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every enabled serial bit must match the next queued bit.
    always @(negedge clk) begin
        if (!rst && bus.dout_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dout_bit", {31'd0, bus.dout}, {31'd0, mon_exp});
            end
        end
    end

    task automatic push_frame(input logic [7:0] d, input logic p);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
        if (PAR_BITS != 0) exp_q.push_back(p);
    endtask

    // Called at a negedge while IDLE; returns 1 ns after the accepting edge.
    task automatic offer(input logic [7:0] d, input logic p, input bit keep_valid);
        check("ready_before_accept", {31'd0, bus.load_ready}, 32'd1);
        bus.load_data  = d;
        bus.load_valid = 1'b1;
        push_frame(d, p);
        @(posedge clk);
        #1;
        bus.load_data = ~d;
        if (!keep_valid) bus.load_valid = 1'b0;
    endtask

    task automatic expect_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            check("dout_en_frame", {31'd0, bus.dout_en}, 32'd1);
            check("busy_frame", {31'd0, bus.busy}, 32'd1);
            check("ready_frame", {31'd0, bus.load_ready}, 32'd0);
        end
        for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge clk);
            check("dout_en_gap", {31'd0, bus.dout_en}, 32'd0);
            check("dout_gap", {31'd0, bus.dout}, 32'd0);
            check("busy_gap", {31'd0, bus.busy}, 32'd1);
            check("done_gap", {31'd0, bus.done}, (g == GAP_CYC - 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("ready_after", {31'd0, bus.load_ready}, 32'd1);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
        check("done_after", {31'd0, bus.done}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        int stray;
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b1};
        vecs[2] = '{8'h3C, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'h00, 1'b0};
        vecs[5] = '{8'h7E, 1'b0};
        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_dout", {31'd0, bus.dout}, 32'd0);
        check("rst_dout_en", {31'd0, bus.dout_en}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_ready_held", {31'd0, bus.load_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.load_ready}, 32'd1);
        check("busy_after_rst", {31'd0, bus.busy}, 32'd0);

        // Table-driven frames; load_data is scrambled after each accept.
        for (int v = 0; v < 6; v++) begin
            offer(vecs[v].data, vecs[v].exp_par, 1'b0);
            expect_frame();
        end

        // Held load_valid: two back-to-back words, each taken exactly once.
        offer(8'h3C, 1'b0, 1'b1);
        expect_frame();
        offer(8'hC3, 1'b0, 1'b0);
        expect_frame();
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.dout_en === 1'b1) stray++;
        end
        check("no_extra_accept", stray, 32'd0);

        // Reset during data bit 4 aborts the frame at once.
        offer(8'hFF, 1'b0, 1'b0);
        repeat (3 + 5) @(negedge clk);
        check("pre_abort_dout", {31'd0, bus.dout}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_dout", {31'd0, bus.dout}, 32'd0);
        check("abort_dout_en", {31'd0, bus.dout_en}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_ready", {31'd0, bus.load_ready}, 32'd0);
        exp_q.delete();
        #1 rst = 1'b0;
        n = 0;
        while (bus.load_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        if (bus.dout_en === 1'b1) @(negedge clk);
        offer(8'hFF, 1'b0, 1'b0);
        expect_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
